wb_interconnect_1xn: RTL

Parametrised single-master, N-slave Wishbone interconnect between the JTAG-driven `wishbone_master` and the peripheral slaves: the DM, LED, UART and future CPU-side slaves. It decodes the upper address bits to select one slave. It forwards one classic (non-pipelined) cycle at a time and returns the read data with `ack`. It terminates a cycle with `err` when the address is unmapped or the selected slave fails to respond within a bounded time.

---
 rtl/wb_interconnect_1xn.sv | 134 +++++++++++++
 1 files changed

// File: rtl/wb_interconnect_1xn.sv
// Single-master, N-slave classic Wishbone interconnect: upper address bits pick a slave,
// one cycle in flight, terminated by ack, or by err on an unmapped address or slave timeout.
module wb_interconnect_1xn #(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            m_addr_i,
  input  logic                             m_we_i,
  input  logic [DATA_WIDTH-1:0]            m_data_i,
  input  logic                             m_cyc_i,
  input  logic                             m_stb_i,
  output logic [DATA_WIDTH-1:0]            m_data_o,
  output logic                             m_ack_o,
  output logic                             m_err_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH-1:0]            s_data_o,
  output logic [NUM_SLAVES-1:0]            s_cyc_o,
  output logic [NUM_SLAVES-1:0]            s_stb_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]            s_ack_i,
  output logic [15:0]                      err_count_o,
  output logic [1:0]                       state_o
);

  // Handshake: a request is accepted in IDLE when m_cyc_i & m_stb_i; the selected slave
  // sees cyc/stb until it acks (or timeout/abort); the master sees exactly one
  // single-cycle ack or err per accepted request, and must drop m_stb_i before the next.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SEL_WIDTH-1:0]   req_sel;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   slave_ack;
  logic [DATA_WIDTH-1:0]  slave_rdata;

  assign req_sel = m_addr_i[ADDR_WIDTH-1 -: SEL_WIDTH];
  assign state_o = state;

  // s_cyc_o is one-hot on the selected slave, so masking drops acks from any other slave.
  assign slave_ack = |(s_ack_i & s_cyc_o);

  always_comb begin
    slave_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == SEL_WIDTH'(k)) slave_rdata = s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_q       <= '0;
      m_data_o    <= '0;
      m_ack_o     <= 1'b0;
      m_err_o     <= 1'b0;
      s_addr_o    <= '0;
      s_we_o      <= 1'b0;
      s_data_o    <= '0;
      s_cyc_o     <= '0;
      s_stb_o     <= '0;
      err_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            s_addr_o <= m_addr_i;
            s_we_o   <= m_we_i;
            s_data_o <= m_data_i;
            sel_q    <= req_sel;
            cnt      <= '0;
            if (int'(req_sel) < NUM_SLAVES) begin
              s_cyc_o <= NUM_SLAVES'(1) << req_sel;
              s_stb_o <= NUM_SLAVES'(1) << req_sel;
              state   <= ACTIVE;
            end else begin
              m_err_o     <= 1'b1;
              m_data_o    <= '0;
              err_count_o <= (err_count_o == 16'hFFFF) ? err_count_o : err_count_o + 16'd1;
              state       <= RESP;
            end
          end
        end
        ACTIVE: begin
          // Ack outranks both the timeout and a same-cycle master abort.
          if (slave_ack) begin
            m_data_o <= slave_rdata;
            m_ack_o  <= 1'b1;
            s_cyc_o  <= '0;
            s_stb_o  <= '0;
            state    <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            m_data_o    <= '0;
            m_err_o     <= 1'b1;
            s_cyc_o     <= '0;
            s_stb_o     <= '0;
            err_count_o <= (err_count_o == 16'hFFFF) ? err_count_o : err_count_o + 16'd1;
            state       <= RESP;
          end else if (!m_cyc_i) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          m_ack_o <= 1'b0;
          m_err_o <= 1'b0;
          state   <= RELEASE;
        end
        RELEASE: begin
          if (!m_stb_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
